// File: rtl/instr_fetch_pkg.sv
// Core-wide constants and types shared by the fetch unit and the control decoder.
package instr_fetch_pkg;

    localparam int unsigned XLEN = 32;

    // Opcode field instr[31:26] values that redirect the program counter.
    localparam logic [5:0] OPC_JUMP = 6'b000010;
    localparam logic [5:0] OPC_BEQ  = 6'b000100;

    // Fetch sequencer states.
    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StHold,
        StDrop
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch bus: instruction-memory request/response plus core-side instruction handoff.
interface instr_fetch_if;
    import instr_fetch_pkg::*;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;
    logic            instr_valid;
    logic            instr_ready;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc_out;
    logic            branch_taken;
    logic            flush;
    logic [XLEN-1:0] flush_pc;

    // Fetch unit side.
    modport master (
        output imem_req, imem_addr, instr_valid, instr, pc_out,
        input  imem_rvalid, imem_rdata, instr_ready, branch_taken, flush, flush_pc
    );

    // Memory/core environment side.
    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, pc_out,
        output imem_rvalid, imem_rdata, instr_ready, branch_taken, flush, flush_pc
    );

endinterface

// File: rtl/instr_fetch_next_pc_calc.sv
// Next-PC selection for the held instruction: jump, taken beq, or sequential.
module instr_fetch_next_pc_calc
    import instr_fetch_pkg::*;
(
    input  logic [XLEN-1:0] pc_out_i,
    input  logic [XLEN-1:0] instr_i,
    input  logic            branch_taken_i,
    output logic [XLEN-1:0] next_pc_o
);

    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] br_off;
    logic [5:0]      opcode;

    // Decode opcode and pick the redirect target; pc4 wraps naturally at 32 bits.
    always_comb begin
        pc4       = pc_out_i + 32'd4;
        opcode    = instr_i[31:26];
        br_off    = {{14{instr_i[15]}}, instr_i[15:0], 2'b00};
        next_pc_o = pc4;
        if (opcode == OPC_JUMP) begin
            next_pc_o = {pc4[31:28], instr_i[25:0], 2'b00};
        end else if ((opcode == OPC_BEQ) && branch_taken_i) begin
            next_pc_o = pc4 + br_off;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns the PC, fetches one word at a time, holds it for the core.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst_n,
    instr_fetch_if.master bus
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] pc_out_q, pc_out_d;
    logic [XLEN-1:0] next_pc;
    logic [XLEN-1:0] flush_tgt;
    logic            xfer;

    assign flush_tgt = bus.flush_pc & 32'hFFFF_FFFC;

    instr_fetch_next_pc_calc u_next_pc_calc (
        .pc_out_i       (pc_out_q),
        .instr_i        (instr_q),
        .branch_taken_i (bus.branch_taken),
        .next_pc_o      (next_pc)
    );

    // Next-state logic; flush overrides everything, including a same-cycle transfer.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        pc_out_d = pc_out_q;
        xfer     = (state_q == StHold) && bus.instr_ready;

        unique case (state_q)
            StIdle: state_d = StWait;
            StWait: begin
                if (bus.imem_rvalid) begin
                    instr_d  = bus.imem_rdata;
                    pc_out_d = pc_q;
                    state_d  = StHold;
                end
            end
            StHold: begin
                if (xfer) begin
                    pc_d    = next_pc;
                    state_d = StWait;
                end
            end
            StDrop: begin
                if (bus.imem_rvalid) begin
                    state_d = StWait;
                end
            end
            default: state_d = StIdle;
        endcase

        if (bus.flush) begin
            pc_d     = flush_tgt;
            instr_d  = instr_q;
            pc_out_d = pc_out_q;
            // An unanswered request must still be drained before a new one can go out.
            if ((state_q == StWait) || (state_q == StDrop)) begin
                state_d = bus.imem_rvalid ? StWait : StDrop;
            end else begin
                state_d = StWait;
            end
        end

        // Request address follows the PC on every entry to (or stay in) StWait, and freezes in
        // StDrop so the abandoned request stays stable until its response arrives.
        addr_d = (state_d == StWait) ? pc_d : addr_q;
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            pc_q     <= RESET_PC;
            addr_q   <= RESET_PC;
            instr_q  <= '0;
            pc_out_q <= RESET_PC;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            addr_q   <= addr_d;
            instr_q  <= instr_d;
            pc_out_q <= pc_out_d;
        end
    end

    assign bus.imem_req    = (state_q == StWait) || (state_q == StDrop);
    assign bus.imem_addr   = addr_q;
    assign bus.instr_valid = (state_q == StHold);
    assign bus.instr       = instr_q;
    assign bus.pc_out      = pc_out_q;

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch unit for the 32-bit single-cycle RISC core: owns the program counter, issues word reads to instruction memory over a request/response handshake, and holds each fetched instruction until the core consumes it. It is the producer of the instruction word (and therefore the opcode) that the main control decoder consumes. It computes the next PC from sequential, jump and taken-branch cases, and supports an asynchronous-to-the-pipeline flush that discards an in-flight memory response.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word aligned.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- imem_req  out  1  read request to instruction memory, held high until imem_rvalid.
- imem_addr  out  32  byte address of requested word, stable while imem_req high.
- imem_rvalid  in  1  response valid; may assert in the same cycle imem_req first rises.
- imem_rdata  in  32  instruction word, sampled when imem_rvalid high.
- instr_valid  out  1  instr/pc_out hold a valid instruction.
- instr_ready  in  1  core consumes instruction this cycle (transfer = instr_valid & instr_ready).
- instr  out  32  held instruction word.
- pc_out  out  32  address of held instruction.
- branch_taken  in  1  ALU zero result for the held instruction; sampled only at transfer.
- flush  in  1  discard current fetch/held instruction and restart at flush_pc.
- flush_pc  in  32  restart address; bits [1:0] ignored (forced 0).

## Operation
- States: S_IDLE, S_WAIT, S_HOLD, S_DROP.
- S_IDLE: reset state; imem_req=0. Next cycle -> S_WAIT.
- S_WAIT: imem_req=1, imem_addr=pc. On imem_rvalid: instr<=imem_rdata, pc_out<=pc, -> S_HOLD.
- S_HOLD: instr_valid=1, imem_req=0. On transfer: pc<=next_pc, -> S_WAIT.
- S_DROP: imem_req=1 held (address of abandoned fetch unchanged) until imem_rvalid; response discarded; -> S_WAIT with pc already = flush_pc.
- next_pc (opcode = instr[31:26], pc4 = pc_out+4, 32-bit wrap-around):
  - opcode 6'b000010 (jump): {pc4[31:28], instr[25:0], 2'b00}.
  - opcode 6'b000100 (beq) and branch_taken: pc4 + ({{14{instr[15]}}, instr[15:0], 2'b00}).
  - otherwise pc4. PC 32'hFFFF_FFFC sequentially wraps to 32'h0000_0000.
- Flush (highest priority, overrides transfer in the same cycle):
  - in S_IDLE or S_HOLD: pc<=flush_pc, instr_valid drops next cycle, -> S_WAIT.
  - in S_WAIT without imem_rvalid that cycle: pc<=flush_pc, -> S_DROP.
  - in S_WAIT with imem_rvalid that cycle: response discarded, pc<=flush_pc, -> S_WAIT.
  - in S_DROP: pc<=flush_pc, stay S_DROP (or -> S_WAIT if imem_rvalid that cycle).
- At most one outstanding memory request at any time.

## Timing
- Reset values: imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=32'h0, pc_out=RESET_PC, state S_IDLE.
- Reset mid-fetch: all state returns to reset values immediately; any later imem_rvalid is the memory's responsibility (memory is reset by same rst_n).
- All outputs registered or decoded from state/registers only; no combinational path from instr_ready/branch_taken to outputs.
- Best-case throughput: 1 instruction per 2 cycles (S_WAIT with same-cycle rvalid, S_HOLD with instr_ready).
- Fetch latency: instr_valid rises the cycle after imem_rvalid.
- instr and pc_out stable while instr_valid=1 and no transfer/flush.

## Structure
- Shared package (core-wide): OPC_JUMP=6'b000010, OPC_BEQ=6'b000100, state enum, XLEN=32; same constants used by the control decoder.
- One natural sub-module: next_pc_calc (combinational jump/branch/sequential target from pc_out, instr, branch_taken).

## Test plan
- Reset release with RESET_PC=0, memory rvalid same cycle: imem_addr 0, 4, 8 on successive fetches; instr_valid rises cycle after rvalid; instr_ready held 1 -> one instruction per 2 cycles.
- Jump: instr 32'h0800_0010 at pc_out 0x0000_0100 consumed -> next imem_addr 0x0000_0040.
- Branch at pc_out 0x0000_0020, instr 32'h1000_FFFE: branch_taken=1 -> next addr 0x0000_001C; branch_taken=0 -> 0x0000_0024.
- Backpressure: instr_ready=0 for 5 cycles in S_HOLD -> imem_req stays 0, instr/pc_out unchanged; release -> single transfer, next fetch issued.
- Flush during S_WAIT with 3-cycle memory latency, flush_pc=0x200: old response dropped (instr_valid stays 0), then imem_addr=0x200 and its word delivered.
- PC wrap: pc_out 0xFFFF_FFFC, non-control opcode consumed -> next imem_addr 0x0000_0000; assert rst_n=0 during S_WAIT -> outputs return to reset values asynchronously.
